// File: rtl/chimp_pkg.sv
// rtl/chimp_pkg.sv - shared state encoding, field widths and game defaults for the chimp sequencer
package chimp_pkg;

  localparam int NUM_W           = 5;
  localparam int STRIKE_W        = 2;
  localparam int START_LEVEL_DEF = 4;
  localparam int MAX_LEVEL_DEF   = 31;
  localparam int MAX_STRIKES_DEF = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_LOAD_GAP,
    S_SHOW,
    S_PLAY,
    S_VERDICT,
    S_FEEDBACK,
    S_GAME_OVER
  } state_t;

endpackage

// File: rtl/chimp_delay_timer.sv
// rtl/chimp_delay_timer.sv - loadable down-counter; done is high while the count rests at zero
module chimp_delay_timer #(
  parameter int CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [W-1:0] LOAD_VALUE = W'(CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/chimp_control.sv
// rtl/chimp_control.sv - round/level sequencer driving the chimp board datapath
module chimp_control
  import chimp_pkg::*;
#(
  parameter int FEEDBACK_CYCLES = 50_000_000,
  parameter int START_LEVEL     = START_LEVEL_DEF,
  parameter int MAX_LEVEL       = MAX_LEVEL_DEF,
  parameter int MAX_STRIKES     = MAX_STRIKES_DEF
) (
  input  logic                clk,
  input  logic                iResetn,
  input  logic                iAbort,
  input  logic                iStart,
  input  logic                iDoneLoad,
  input  logic                iClick,
  input  logic                iChoseCorrect,
  input  logic                iChoseWrong,
  output logic                oResetBoard,
  output logic                oLoadEnable,
  output logic [NUM_W-1:0]    oLoadNum,
  output logic                oShowEnable,
  output logic [NUM_W-1:0]    oChooseNum,
  output logic [NUM_W-1:0]    oLevel,
  output logic [STRIKE_W-1:0] oStrikes,
  output logic                oGameOver,
  output logic                oWin
);

  localparam logic [NUM_W-1:0]    LVL_START   = NUM_W'(START_LEVEL);
  localparam logic [NUM_W-1:0]    LVL_MAX     = NUM_W'(MAX_LEVEL);
  localparam logic [STRIKE_W-1:0] STRIKES_MAX = STRIKE_W'(MAX_STRIKES);

  state_t                state, state_next;
  logic [NUM_W-1:0]      level, level_next;
  logic [NUM_W-1:0]      load_num, load_num_next;
  logic [NUM_W-1:0]      choose_num, choose_num_next;
  logic [STRIKE_W-1:0]   strikes, strikes_next;
  logic                  win, win_next;
  logic                  show, show_next;
  logic                  game_over, game_over_next;
  logic                  timer_load, timer_done;

  chimp_delay_timer #(.CYCLES(FEEDBACK_CYCLES)) u_feedback_timer (
    .clk   (clk),
    .rst_n (iResetn),
    .load  (timer_load),
    .done  (timer_done)
  );

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state       <= S_IDLE;
      level       <= '0;
      load_num    <= '0;
      choose_num  <= '0;
      strikes     <= '0;
      win         <= 1'b0;
      show        <= 1'b0;
      game_over   <= 1'b0;
      oResetBoard <= 1'b0;
      oLoadEnable <= 1'b0;
    end else begin
      state       <= state_next;
      level       <= level_next;
      load_num    <= load_num_next;
      choose_num  <= choose_num_next;
      strikes     <= strikes_next;
      win         <= win_next;
      show        <= show_next;
      game_over   <= game_over_next;
      oResetBoard <= (state_next == S_CLEAR);
      oLoadEnable <= (state_next == S_LOAD);
    end
  end

  always_comb begin
    state_next      = state;
    level_next      = level;
    load_num_next   = load_num;
    choose_num_next = choose_num;
    strikes_next    = strikes;
    win_next        = win;
    show_next       = show;
    game_over_next  = game_over;
    timer_load      = 1'b0;

    case (state)
      S_IDLE, S_GAME_OVER: begin
        if (iStart) begin
          level_next     = LVL_START;
          strikes_next   = '0;
          win_next       = 1'b0;
          game_over_next = 1'b0;
          state_next     = S_CLEAR;
        end
      end
      S_CLEAR: state_next = S_LOAD;
      S_LOAD: begin
        if (iDoneLoad) begin
          if (load_num == level) begin
            show_next  = 1'b1;
            state_next = S_SHOW;
          end else begin
            load_num_next = load_num + NUM_W'(1);
            state_next    = S_LOAD_GAP;
          end
        end
      end
      S_LOAD_GAP: state_next = S_LOAD;
      S_SHOW: begin
        if (iClick) begin
          show_next  = 1'b0;
          state_next = S_VERDICT;
        end
      end
      S_PLAY: begin
        if (iClick) state_next = S_VERDICT;
      end
      S_VERDICT: begin
        // a simultaneous correct+wrong pulse is judged as wrong
        if (iChoseWrong) begin
          if (strikes != STRIKES_MAX) strikes_next = strikes + STRIKE_W'(1);
          show_next  = 1'b1;
          timer_load = 1'b1;
          state_next = S_FEEDBACK;
        end else if (iChoseCorrect) begin
          if (choose_num != level) begin
            choose_num_next = choose_num + NUM_W'(1);
            state_next      = S_PLAY;
          end else begin
            if (level < LVL_MAX) level_next = level + NUM_W'(1);
            else                 win_next   = 1'b1;
            timer_load = 1'b1;
            state_next = S_FEEDBACK;
          end
        end
      end
      S_FEEDBACK: begin
        if (timer_done) begin
          if (win || strikes == STRIKES_MAX) begin
            game_over_next = 1'b1;
            state_next     = S_GAME_OVER;
          end else begin
            state_next = S_CLEAR;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (iAbort) begin
      state_next = S_IDLE;
      show_next  = 1'b0;
      timer_load = 1'b0;
    end

    // counters are primed on entry so they are already valid while the board clears
    if (state_next == S_CLEAR) begin
      load_num_next   = NUM_W'(1);
      choose_num_next = NUM_W'(1);
      show_next       = 1'b0;
    end
  end

  assign oLoadNum    = load_num;
  assign oShowEnable = show;
  assign oChooseNum  = choose_num;
  assign oLevel      = level;
  assign oStrikes    = strikes;
  assign oGameOver   = game_over;
  assign oWin        = win;

endmodule

// File: tb/tb_chimp_control.sv
// tb/tb_chimp_control.sv - randomized scoreboard bench for chimp_control
module tb_chimp_control;

  logic       clk = 1'b0;
  logic       iResetn = 1'b0;
  logic       iAbort = 1'b0;
  logic       iStart = 1'b0;
  logic       iDoneLoad = 1'b0;
  logic       iClick = 1'b0;
  logic       iChoseCorrect = 1'b0;
  logic       iChoseWrong = 1'b0;
  logic       oResetBoard, oLoadEnable, oShowEnable, oGameOver, oWin;
  logic [4:0] oLoadNum, oChooseNum, oLevel;
  logic [1:0] oStrikes;

  always #5 clk = ~clk;

  chimp_control #(.FEEDBACK_CYCLES(4)) dut (
    .clk           (clk),
    .iResetn       (iResetn),
    .iAbort        (iAbort),
    .iStart        (iStart),
    .iDoneLoad     (iDoneLoad),
    .iClick        (iClick),
    .iChoseCorrect (iChoseCorrect),
    .iChoseWrong   (iChoseWrong),
    .oResetBoard   (oResetBoard),
    .oLoadEnable   (oLoadEnable),
    .oLoadNum      (oLoadNum),
    .oShowEnable   (oShowEnable),
    .oChooseNum    (oChooseNum),
    .oLevel        (oLevel),
    .oStrikes      (oStrikes),
    .oGameOver     (oGameOver),
    .oWin          (oWin)
  );

  typedef enum int {EV_CLEAR, EV_LOAD, EV_SHOW_ON, EV_SHOW_OFF, EV_CHOOSE, EV_LEVEL, EV_OVER} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int a, b, c, d, e;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  m_level = 0;
  int  m_strikes = 0;
  bit  m_win = 1'b0;

  task automatic push(input ev_kind_t k, input int a, input int b = 0, input int c = 0,
                      input int d = 0, input int e = 0);
    ev_t ev;
    ev.kind = k; ev.a = a; ev.b = b; ev.c = c; ev.d = d; ev.e = e;
    exp_q.push_back(ev);
  endtask

  task automatic observe(input ev_kind_t k, input int a, input int b, input int c,
                         input int d, input int e);
    ev_t ex;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s got a=%0d b=%0d c=%0d d=%0d e=%0d required no event",
               k.name(), a, b, c, d, e);
    end else begin
      ex = exp_q.pop_front();
      if (ex.kind != k || ex.a != a || ex.b != b || ex.c != c || ex.d != d || ex.e != e) begin
        errors++;
        $display("FAIL event got %s a=%0d b=%0d c=%0d d=%0d e=%0d required %s a=%0d b=%0d c=%0d d=%0d e=%0d",
                 k.name(), a, b, c, d, e, ex.kind.name(), ex.a, ex.b, ex.c, ex.d, ex.e);
      end
    end
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_reset_board"}, int'(oResetBoard), 0);
    check_eq({tag, "_load_en"},     int'(oLoadEnable), 0);
    check_eq({tag, "_load_num"},    int'(oLoadNum), 0);
    check_eq({tag, "_show"},        int'(oShowEnable), 0);
    check_eq({tag, "_choose"},      int'(oChooseNum), 0);
    check_eq({tag, "_level"},       int'(oLevel), 0);
    check_eq({tag, "_strikes"},     int'(oStrikes), 0);
    check_eq({tag, "_game_over"},   int'(oGameOver), 0);
    check_eq({tag, "_win"},         int'(oWin), 0);
  endtask

  // Monitor: turns output edges into events and matches them against the scoreboard
  logic       p_rb = 1'b0, p_le = 1'b0, p_show = 1'b0, p_go = 1'b0;
  logic [4:0] p_choose = '0, p_level = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (oResetBoard && !p_rb)
        observe(EV_CLEAR, int'(oLevel), int'(oStrikes), int'(oChooseNum), int'(oShowEnable),
                int'({oGameOver, oWin}));
      if (oLoadEnable && !p_le)
        observe(EV_LOAD, int'(oLoadNum), int'(oResetBoard), 0, 0, 0);
      if (oShowEnable && !p_show)
        observe(EV_SHOW_ON, int'(oChooseNum), int'(oStrikes), 0, 0, 0);
      if (!oShowEnable && p_show && !oResetBoard)
        observe(EV_SHOW_OFF, int'(oChooseNum), 0, 0, 0, 0);
      if (oChooseNum != p_choose && !oResetBoard)
        observe(EV_CHOOSE, int'(oChooseNum), 0, 0, 0, 0);
      if (oLevel != p_level && !oResetBoard)
        observe(EV_LEVEL, int'(oLevel), 0, 0, 0, 0);
      if (oGameOver && !p_go)
        observe(EV_OVER, int'(oWin), int'(oLevel), int'(oStrikes), 0, 0);
    end
    p_rb = oResetBoard; p_le = oLoadEnable; p_show = oShowEnable; p_go = oGameOver;
    p_choose = oChooseNum; p_level = oLevel;
  end

  function automatic bit sig_val(input int which);
    case (which)
      0:       return oLoadEnable;
      1:       return oShowEnable;
      default: return oGameOver;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int budget;
    budget = 3000;
    while (!sig_val(which)) begin
      @(negedge clk);
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL timeout_%s got low required high", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
        forever @(negedge clk);
      end
    end
  endtask

  task automatic start_game();
    iStart = 1'b1;
    m_level = 4; m_strikes = 0; m_win = 1'b0;
    push(EV_CLEAR, 4, 0, 1, 0, 0);
    push(EV_LOAD, 1, 0);
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic round_end(output int result);
    if (m_win || m_strikes == 3) begin
      push(EV_OVER, int'(m_win), m_level, m_strikes);
      result = 1;
    end else begin
      push(EV_CLEAR, m_level, m_strikes, 1, 0, 0);
      push(EV_LOAD, 1, 0);
      result = 0;
    end
  endtask

  task automatic load_phase(input int reset_at, output bit did_reset);
    did_reset = 1'b0;
    for (int n = 1; n <= m_level; n++) begin
      wait_sig(0, "load_enable");
      if (n == reset_at) begin
        check_eq("pre_reset_level", int'(oLevel), m_level);
        check_eq("pre_reset_load_num", int'(oLoadNum), n);
        #2;
        mon_en = 1'b0;
        iResetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        check_eq("queue_at_reset", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        iResetn = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        did_reset = 1'b1;
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      iDoneLoad = 1'b1;
      if (n < m_level) push(EV_LOAD, n + 1, 0);
      else             push(EV_SHOW_ON, 1, m_strikes);
      // a two-cycle hold lands the second cycle in the gap, where it must be ignored
      repeat ($urandom_range(1, 2)) @(negedge clk);
      iDoneLoad = 1'b0;
    end
  endtask

  task automatic click_phase(input int mode, input int abort_at, input bit force_both,
                             output int result);
    int lvl;
    int fail_at;
    lvl = m_level;
    result = 0;
    fail_at = 0;
    if (mode == 2) fail_at = int'($urandom_range(1, lvl));
    else if (mode == 1 && $urandom_range(0, 2) == 0) fail_at = int'($urandom_range(1, lvl));
    wait_sig(1, "show_enable");
    for (int i = 1; i <= lvl; i++) begin
      iClick = 1'b1;
      if (i == 1) push(EV_SHOW_OFF, 1);
      @(negedge clk);
      iClick = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        iClick = ($urandom_range(0, 2) == 0);
        @(negedge clk);
        iClick = 1'b0;
      end
      if (i == abort_at) begin
        iAbort = 1'b1;
        @(negedge clk);
        iAbort = 1'b0;
        iChoseCorrect = 1'b1;
        iClick = 1'b1;
        @(negedge clk);
        iChoseCorrect = 1'b0;
        iClick = 1'b0;
        result = 2;
        return;
      end
      if (i == fail_at) begin
        iChoseWrong = 1'b1;
        iChoseCorrect = force_both || ($urandom_range(0, 1) == 1);
        if (m_strikes < 3) m_strikes++;
        push(EV_SHOW_ON, i, m_strikes);
        round_end(result);
      end else begin
        iChoseCorrect = 1'b1;
        if (i < lvl) begin
          push(EV_CHOOSE, i + 1);
        end else begin
          if (m_level < 31) begin
            m_level++;
            push(EV_LEVEL, m_level);
          end else begin
            m_win = 1'b1;
          end
          round_end(result);
        end
      end
      @(negedge clk);
      iChoseCorrect = 1'b0;
      iChoseWrong = 1'b0;
      if (i == fail_at || i == lvl) begin
        iClick = 1'($urandom_range(0, 1));
        @(negedge clk);
        iClick = 1'b0;
        return;
      end
    end
  endtask

  task automatic play_round(input int mode, input int abort_at, input bit force_both,
                            output int result);
    bit r;
    load_phase(0, r);
    click_phase(mode, abort_at, force_both, result);
  endtask

  initial begin
    int  res;
    bit  rst_done;
    repeat (3) @(negedge clk);
    check_outputs_zero("por");
    iResetn = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    start_game();
    play_round(0, 0, 1'b0, res);
    play_round(0, 0, 1'b0, res);
    load_phase(3, rst_done);

    start_game();
    play_round(2, 0, 1'b1, res);
    play_round(2, 0, 1'b0, res);
    play_round(2, 0, 1'b0, res);
    wait_sig(2, "three_strike_game_over");

    start_game();
    play_round(0, 0, 1'b0, res);
    play_round(0, 2, 1'b0, res);
    repeat (3) @(negedge clk);

    start_game();
    res = 0;
    for (int r = 0; r < 40 && res != 1; r++) play_round((r < 8) ? 1 : 2, 0, 1'b0, res);
    wait_sig(2, "random_game_over");

    start_game();
    res = 0;
    for (int r = 0; r < 40 && res != 1; r++) play_round(0, 0, 1'b0, res);
    wait_sig(2, "win_game_over");

    repeat (5) @(negedge clk);
    check_eq("events_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chimp_control.md
# chimp_control

Round/level sequencer for the chimp memory game. It drives the chimp board datapath through the game cycle: clear, load numbers 1..L into random free cells, show, hide on the first click, then judge clicks in order. It also tracks level, strikes and game-over. It sits between the game-select/menu logic and the board datapath, and owns every datapath control strobe.

## Interface
Parameters:
- FEEDBACK_CYCLES, 50_000_000: board-hold time after a round ends (1 s at 50 MHz).
- START_LEVEL, 4: count of numbers in the first round.
- MAX_LEVEL, 31: highest level; bound set by the 5-bit number field.
- MAX_STRIKES, 3: wrong rounds allowed before game over.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge.
- iResetn  in  1  asynchronous, active-low reset.
- iAbort  in  1  KEY0 press; synchronous return to IDLE from any state.
- iStart  in  1  chimp game selected/start pulse.
- iDoneLoad  in  1  datapath accepted the current load into a free cell.
- iClick  in  1  one-cycle mouse click pulse on a board cell.
- iChoseCorrect  in  1  datapath verdict pulse: the clicked cell matches oChooseNum.
- iChoseWrong  in  1  datapath verdict pulse: mismatch.
- oResetBoard  out  1  one-cycle board clear strobe.
- oLoadEnable  out  1  load request to the datapath.
- oLoadNum  out  5  number being loaded, 1..L.
- oShowEnable  out  1  numbers visible.
- oChooseNum  out  5  next number the player must click.
- oLevel  out  5  current level L.
- oStrikes  out  2  strikes so far.
- oGameOver  out  1  game finished.
- oWin  out  1  game finished by clearing MAX_LEVEL.

## Operation
- States: IDLE, CLEAR, LOAD, LOAD_GAP, SHOW, PLAY, VERDICT, FEEDBACK, GAME_OVER.
- IDLE:
  - iStart sets level=START_LEVEL, strikes=0, win=0, then goes to CLEAR.
- CLEAR:
  - oResetBoard=1 for exactly one cycle.
  - loadNum=1, chooseNum=1.
  - Next state is LOAD.
- LOAD:
  - oLoadEnable=1 with oLoadNum=loadNum.
  - Hold until iDoneLoad. Retries into occupied cells are the datapath's concern; the random source changes every cycle.
  - On iDoneLoad: if loadNum==level go to SHOW; otherwise loadNum++ and go to LOAD_GAP.
- LOAD_GAP:
  - oLoadEnable=0 for one cycle so one request never loads twice.
  - Return to LOAD.
- SHOW:
  - oShowEnable=1.
  - iClick clears oShowEnable and goes to VERDICT. The first click both hides the numbers and is judged.
- PLAY:
  - oShowEnable=0.
  - iClick goes to VERDICT.
  - Clicks arriving in any other state are ignored.
- VERDICT: wait for a verdict pulse.
  - Correct with chooseNum<level: chooseNum++, go to PLAY.
  - Correct with chooseNum==level (round won): level++ if level<MAX_LEVEL; otherwise set win=1. Load the timer, go to FEEDBACK.
  - Wrong: strikes++, oShowEnable=1 (reveal), load the timer, go to FEEDBACK.
  - Correct and wrong in the same cycle counts as wrong.
- FEEDBACK:
  - Count FEEDBACK_CYCLES down to 0.
  - On expiry: go to GAME_OVER if win, or if strikes==MAX_STRIKES; otherwise go to CLEAR.
- GAME_OVER:
  - oGameOver=1, outputs frozen.
  - iStart behaves as it does in IDLE.
- iAbort has priority over every transition: next state is IDLE and strobes drop.
- Width rules:
  - level saturates at MAX_LEVEL.
  - strikes never exceeds MAX_STRIKES.
  - Counters never wrap.

## Timing
- Reset (iResetn low, asynchronous): state=IDLE; every output 0, including oLevel=0 and oStrikes=0.
- All outputs are registered, so each output changes one cycle after the qualifying input edge.
- iDoneLoad is sampled only in LOAD. A stale iDoneLoad in LOAD_GAP is ignored.
- Minimum load phase for level L: 2L-1 cycles after CLEAR.
- oResetBoard and oLoadEnable are never high in the same cycle.
- A verdict pulse may arrive any number of cycles after iClick. No timeout applies; iAbort is the only escape.
- iClick in VERDICT or FEEDBACK is dropped.

## Structure
- Package chimp_pkg holds:
  - the state enum;
  - the START_LEVEL, MAX_LEVEL and MAX_STRIKES defaults;
  - the 5-bit number and 2-bit strike widths.
- Sub-module chimp_delay_timer: a loadable down-counter with a done flag, sized $clog2(FEEDBACK_CYCLES+1). It is reusable by the other game FSMs.

## Test plan
- Reset mid-LOAD: drop iResetn with level=6, loadNum=3 -> all outputs 0 at once, state IDLE.
- iStart, with iDoneLoad given 2 cycles after each oLoadEnable rise:
  - oResetBoard pulses once;
  - oLoadNum steps 1,2,3,4 with a one-cycle low gap between requests;
  - SHOW is entered with oShowEnable=1.
- Full correct round at level 4:
  - the first click drops oShowEnable;
  - four iChoseCorrect pulses make oChooseNum run 1..4, then oLevel=5 after FEEDBACK, and a new CLEAR follows.
- Three wrong rounds (FEEDBACK_CYCLES=4): oStrikes goes 1, 2, 3, then oGameOver=1 with oWin=0; a further iStart resets oLevel=4 and oStrikes=0.
- Simultaneous iChoseCorrect and iChoseWrong -> counted as a strike; oChooseNum unchanged.
- At level 31, a winning round -> oWin=1, oGameOver=1, oLevel stays 31. iAbort during VERDICT -> IDLE next cycle.
